text_scanout: RTL and testbench

- Character-mode video scanout controller. Sequences the Font bitmap ROM from the VGA pixel timing stream.
- Each pixel: converts the incoming coordinate to a text-buffer address, reads the character code from a synchronous text RAM, drives the Font lookup, and selects one bitmap bit.
- Overlays a blinking underline cursor.
- Sits between the VGA timing generator and the colour/output stage.
- Sync signals pass through with the same latency as the pixel, so outputs stay aligned.

---
 rtl/text_scanout.sv | 163 ++++++++++++++++
 tb/tb_text_scanout.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_scanout.sv
// Character-mode scanout: pixel coordinate -> text RAM -> font bitmap -> pixel,
// with a blinking underline cursor and syncs delayed to match the pixel path.

package PKGFont;
    localparam int chars     = 81;
    localparam int CHAR_BITS = 7;
    localparam int FONT_BITS = 128;
    typedef logic [CHAR_BITS-1:0] bitsChar;
    typedef logic [FONT_BITS-1:0] bitsFont;
endpackage

module text_scanout #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int BLINK_FRAMES = 32,
    parameter int ADDR_W       = $clog2(COLS * ROWS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [9:0]          pixelX,
    input  logic [9:0]          pixelY,
    input  logic                activeIn,
    input  logic                hsyncIn,
    input  logic                vsyncIn,
    input  logic                frameStart,
    output logic [ADDR_W-1:0]   textAddr,
    input  PKGFont::bitsChar    textData,
    output PKGFont::bitsChar    fontChar,
    input  PKGFont::bitsFont    fontBitmap,
    input  logic [6:0]          cursorCol,
    input  logic [4:0]          cursorRow,
    input  logic                cursorEnable,
    output logic                pixelOut,
    output logic                activeOut,
    output logic                hsyncOut,
    output logic                vsyncOut
);

    localparam int FONT_BITS = $bits(PKGFont::bitsFont);
    localparam int IDX_W     = $clog2(FONT_BITS);
    localparam int CNT_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [6:0]        cell_col;
    logic [5:0]        cell_row;
    logic              in_grid;
    logic [ADDR_W-1:0] cell_addr;

    logic [6:0]        s1_col;
    logic [5:0]        s1_row;
    logic [2:0]        s1_gx;
    logic [3:0]        s1_gy;
    logic              s1_in_grid;
    logic              s1_active;
    logic              s1_hsync;
    logic              s1_vsync;

    logic [2:0]        s2_gx;
    logic [3:0]        s2_gy;
    logic              s2_in_grid;
    logic              s2_active;
    logic              s2_hsync;
    logic              s2_vsync;
    logic              s2_hit;

    logic [CNT_W-1:0]  blink_cnt;
    logic              blink_phase;

    logic              code_valid;
    logic [IDX_W-1:0]  bit_idx;
    logic              glyph_bit;

    always_comb begin
        cell_col  = pixelX[9:3];
        cell_row  = pixelY[9:4];
        in_grid   = activeIn && (int'(cell_col) < COLS) && (int'(cell_row) < ROWS);
        cell_addr = ADDR_W'(cell_row) * ADDR_W'(COLS) + ADDR_W'(cell_col);
    end

    // Out-of-range codes address glyph 0 but are masked to blank below.
    always_comb begin
        code_valid = int'(textData) < PKGFont::chars;
        fontChar   = code_valid ? textData : '0;
        bit_idx    = IDX_W'(FONT_BITS - 1) - IDX_W'({s2_gy, s2_gx});
        glyph_bit  = code_valid && fontBitmap[bit_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_col     <= '0;
            s1_row     <= '0;
            s1_gx      <= '0;
            s1_gy      <= '0;
            s1_in_grid <= 1'b0;
            s1_active  <= 1'b0;
            s1_hsync   <= 1'b0;
            s1_vsync   <= 1'b0;
            textAddr   <= '0;
        end else begin
            s1_col     <= cell_col;
            s1_row     <= cell_row;
            s1_gx      <= pixelX[2:0];
            s1_gy      <= pixelY[3:0];
            s1_in_grid <= in_grid;
            s1_active  <= activeIn;
            s1_hsync   <= hsyncIn;
            s1_vsync   <= vsyncIn;
            textAddr   <= in_grid ? cell_addr : '0;
        end
    end

    // Cursor hit is gated by in_grid so off-grid cursor coordinates never match.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_gx      <= '0;
            s2_gy      <= '0;
            s2_in_grid <= 1'b0;
            s2_active  <= 1'b0;
            s2_hsync   <= 1'b0;
            s2_vsync   <= 1'b0;
            s2_hit     <= 1'b0;
        end else begin
            s2_gx      <= s1_gx;
            s2_gy      <= s1_gy;
            s2_in_grid <= s1_in_grid;
            s2_active  <= s1_active;
            s2_hsync   <= s1_hsync;
            s2_vsync   <= s1_vsync;
            s2_hit     <= cursorEnable && blink_phase && s1_in_grid &&
                          (s1_col == cursorCol) && (s1_row == {1'b0, cursorRow}) &&
                          (s1_gy >= 4'd14);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixelOut  <= 1'b0;
            activeOut <= 1'b0;
            hsyncOut  <= 1'b0;
            vsyncOut  <= 1'b0;
        end else begin
            pixelOut  <= s2_in_grid && s2_active && (glyph_bit ^ s2_hit);
            activeOut <= s2_active;
            hsyncOut  <= s2_hsync;
            vsyncOut  <= s2_vsync;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frameStart) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_text_scanout.sv
// Bench for text_scanout: directed table, hand sequences and random traffic,
// all checked against a per-pixel model of the character display.

module tb_text_scanout;

    localparam int COLS  = 80;
    localparam int ROWS  = 30;
    localparam int BF    = 2;
    localparam int AW    = 12;
    localparam int NCELL = COLS * ROWS;
    localparam int NCHAR = 81;
    localparam logic [127:0] GLYPH5 = 128'h80183C66_667E6666_66000000_0000FF81;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [9:0]       pixelX, pixelY;
    logic             activeIn, hsyncIn, vsyncIn, frameStart;
    logic [AW-1:0]    textAddr;
    PKGFont::bitsChar textData;
    PKGFont::bitsChar fontChar;
    PKGFont::bitsFont fontBitmap;
    logic [6:0]       cursorCol;
    logic [4:0]       cursorRow;
    logic             cursorEnable;
    logic             pixelOut, activeOut, hsyncOut, vsyncOut;

    always #5 clk = ~clk;

    text_scanout #(.COLS(COLS), .ROWS(ROWS), .BLINK_FRAMES(BF), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .pixelX(pixelX), .pixelY(pixelY),
        .activeIn(activeIn), .hsyncIn(hsyncIn), .vsyncIn(vsyncIn),
        .frameStart(frameStart), .textAddr(textAddr), .textData(textData),
        .fontChar(fontChar), .fontBitmap(fontBitmap), .cursorCol(cursorCol),
        .cursorRow(cursorRow), .cursorEnable(cursorEnable), .pixelOut(pixelOut),
        .activeOut(activeOut), .hsyncOut(hsyncOut), .vsyncOut(vsyncOut)
    );

    logic [6:0]   ram  [0:NCELL-1];
    logic [127:0] font [0:NCHAR-1];

    always @(posedge clk) textData <= (int'(textAddr) < NCELL) ? ram[textAddr] : 7'd0;
    assign fontBitmap = (int'(fontChar) < NCHAR) ? font[fontChar] : 128'd0;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    endtask

    typedef struct {
        int x, y;
        bit act, hs, vs, fs, rst, cen;
        int ccol, crow;
    } samp_t;

    samp_t hist[$];
    int    fcnt[$];

    function automatic int addr_of(samp_t p);
        int col = p.x / 8, row = p.y / 16;
        if (p.act && col < COLS && row < ROWS) return row * COLS + col;
        return 0;
    endfunction

    function automatic bit pix_of(samp_t p, samp_t c, int ph);
        int col = p.x / 8, row = p.y / 16, gx = p.x % 8, gy = p.y % 16;
        logic [6:0]   code;
        logic [127:0] f;
        bit g, hit;
        if (!(p.act && col < COLS && row < ROWS)) return 1'b0;
        code = ram[row * COLS + col];
        g = 1'b0;
        if (int'(code) < NCHAR) begin
            f = font[code];
            g = f[127 - (gy * 8 + gx)];
        end
        hit = c.cen && (ph == 1) && (col == c.ccol) && (row == c.crow) && (gy >= 14);
        return g ^ hit;
    endfunction

    // Every edge: record what the DUT sampled, then check outputs against
    // the pixel sampled two edges earlier (three cycles after it was driven).
    always begin : monitor
        samp_t s, p, c;
        int n, fc, ph;
        bit e_pix, e_act, e_hs, e_vs;
        @(posedge clk);
        s.x = int'(pixelX); s.y = int'(pixelY); s.act = activeIn;
        s.hs = hsyncIn; s.vs = vsyncIn; s.fs = frameStart; s.rst = rst_n;
        s.cen = cursorEnable; s.ccol = int'(cursorCol); s.crow = int'(cursorRow);
        fc = !rst_n ? 0 : ((fcnt.size() == 0) ? 0 : fcnt[$]) + int'(frameStart);
        hist.push_back(s);
        fcnt.push_back(fc);
        n = hist.size() - 1;
        #1;
        {e_pix, e_act, e_hs, e_vs} = 4'b0;
        if (n >= 2 && hist[n].rst && hist[n-1].rst && hist[n-2].rst) begin
            p = hist[n-2];
            c = hist[n-1];
            ph = (fcnt[n-2] / BF) % 2;
            e_pix = pix_of(p, c, ph);
            e_act = p.act; e_hs = p.hs; e_vs = p.vs;
        end
        chk("mon_addr", 128'(textAddr), s.rst ? 128'(addr_of(s)) : 128'd0);
        chk("mon_pix",  128'(pixelOut),  128'(e_pix));
        chk("mon_act",  128'(activeOut), 128'(e_act));
        chk("mon_hs",   128'(hsyncOut),  128'(e_hs));
        chk("mon_vs",   128'(vsyncOut),  128'(e_vs));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_px(input int x, input int y, input bit act);
        pixelX = 10'(x); pixelY = 10'(y); activeIn = act;
    endtask

    task automatic idle();
        drive_px(0, 0, 1'b0);
        hsyncIn = 1'b0; vsyncIn = 1'b0; frameStart = 1'b0;
    endtask

    typedef struct {
        int x, y;
        bit act;
        int exp_addr;
        bit exp_pix;
    } vec_t;

    vec_t vecs[9];
    logic [127:0] got;

    initial begin
        for (int i = 0; i < NCELL; i++) ram[i] = 7'($urandom_range(0, 127));
        for (int i = 0; i < NCHAR; i++) font[i] = {$urandom, $urandom, $urandom, $urandom};
        font[0] = '0;
        font[5] = GLYPH5;
        ram[81] = 7'd5;  ram[82] = 7'd100;  ram[163] = 7'd0;  ram[2399] = 7'd100;

        vecs[0] = '{8,    16,   1'b1, 81,   1'b1};
        vecs[1] = '{9,    16,   1'b1, 81,   1'b0};
        vecs[2] = '{15,   31,   1'b1, 81,   1'b1};
        vecs[3] = '{8,    16,   1'b0, 0,    1'b0};
        vecs[4] = '{640,  16,   1'b1, 0,    1'b0};
        vecs[5] = '{8,    480,  1'b1, 0,    1'b0};
        vecs[6] = '{639,  479,  1'b1, 2399, 1'b0};
        vecs[7] = '{1023, 1023, 1'b1, 0,    1'b0};
        vecs[8] = '{16,   16,   1'b1, 82,   1'b0};

        cursorCol = '0; cursorRow = '0; cursorEnable = 1'b0;
        idle();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_px($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom));
            hsyncIn = 1'($urandom); vsyncIn = 1'($urandom); frameStart = 1'($urandom);
            cyc();
        end
        idle();
        rst_n = 1'b1;
        repeat (4) cyc();

        // Sync alignment: one-cycle hsync pulse emerges exactly three cycles later
        hsyncIn = 1'b1;
        cyc();
        hsyncIn = 1'b0;
        chk("hs_lat1", 128'(hsyncOut), 128'd0);
        cyc(); chk("hs_lat2", 128'(hsyncOut), 128'd0);
        cyc(); chk("hs_lat3", 128'(hsyncOut), 128'd1);
        cyc(); chk("hs_lat4", 128'(hsyncOut), 128'd0);

        foreach (vecs[i]) begin
            drive_px(vecs[i].x, vecs[i].y, vecs[i].act);
            cyc();
            chk("vec_addr", 128'(textAddr), 128'(vecs[i].exp_addr));
            idle();
            cyc(); cyc();
            chk("vec_pix", 128'(pixelOut), 128'(vecs[i].exp_pix));
        end
        repeat (3) cyc();

        // Full glyph scan of cell (1,1), pipelined back to back
        got = '0;
        for (int i = 0; i < 130; i++) begin
            if (i < 128) drive_px(8 + i % 8, 16 + i / 8, 1'b1);
            else idle();
            cyc();
            if (i < 128) chk("glyph_addr", 128'(textAddr), 128'd81);
            if (i >= 2) got[127 - (i - 2)] = pixelOut;
        end
        chk("glyph5", got, GLYPH5);

        // Cell (2,1) holds code 100: font index forced to 0, cell blank
        got = '0;
        for (int i = 0; i < 130; i++) begin
            if (i < 128) drive_px(16 + i % 8, 16 + i / 8, 1'b1);
            else idle();
            cyc();
            if (i >= 1 && i <= 128) chk("oor_fontchar", 128'(fontChar), 128'd0);
            if (i >= 2) got[127 - (i - 2)] = pixelOut;
        end
        chk("oor_blank", got, 128'd0);

        // Cursor blink on blank cell (3,2): off/off/on/on/off/off by frame
        idle();
        rst_n = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        cursorCol = 7'd3; cursorRow = 5'd2; cursorEnable = 1'b1;
        cyc();
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 34; i++) begin
                if (i < 32) drive_px(24 + i % 8, 44 + i / 8, 1'b1);
                else idle();
                cyc();
                if (i >= 2)
                    chk("blink", 128'(pixelOut),
                        128'((44 + (i - 2) / 8 >= 46) && ((k / 2) % 2 == 1)));
            end
            frameStart = 1'b1;
            cyc();
            frameStart = 1'b0;
        end
        cursorEnable = 1'b0;

        // Random traffic, including mid-frame resets and cursor moves
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                cursorCol = 7'($urandom_range(0, 85));
                cursorRow = 5'($urandom_range(0, 31));
                cursorEnable = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 3) == 0)
                drive_px(int'(cursorCol) * 8 + $urandom_range(0, 7),
                         int'(cursorRow) * 16 + 12 + $urandom_range(0, 3), 1'b1);
            else if ($urandom_range(0, 1) == 0)
                drive_px($urandom_range(0, 1023), $urandom_range(0, 1023), 1'($urandom));
            else
                drive_px($urandom_range(0, 700), $urandom_range(0, 520), $urandom_range(0, 7) != 0);
            hsyncIn = 1'($urandom); vsyncIn = 1'($urandom);
            frameStart = ($urandom_range(0, 19) == 0);
            rst_n = ($urandom_range(0, 199) != 0);
            cyc();
        end
        idle();
        rst_n = 1'b1;
        repeat (4) cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
